// File: rtl/regfile_pkg.sv
// Shared constants, address-width helper and default-sized port array types
// for the multiport register file.
package regfile_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 32;

    function automatic int unsigned addr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned DEF_AW = addr_bits(DEF_DEPTH);

    typedef logic [DEF_WIDTH-1:0] word_t;
    typedef logic [DEF_AW-1:0]    addr_t;
    typedef word_t [1:0]          word2_t;
    typedef addr_t [1:0]          addr2_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set by issue, cleared by committed writes,
// with set taking priority when both hit the same register on one edge.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NWR      = 1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = addr_bits(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set,
    input  logic [AW-1:0]          set_addr,
    input  logic [NWR-1:0]         clr,
    input  logic [NWR-1:0][AW-1:0] clr_addr,
    output logic [DEPTH-1:0]       busy
);

    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        set_vec[set_addr] = set && !(ZERO_REG && set_addr == '0);
        for (int unsigned i = 0; i < NWR; i++) begin
            if (clr[i]) clr_vec[clr_addr[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~clr_vec) | set_vec;
    end

endmodule

// File: rtl/multiport_regfile.sv
// Flop-based register file with NRD combinational read ports, up to two
// write ports, optional write-to-read bypass, hard-zero r0 and a scoreboard.
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = addr_bits(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NWR-1:0]            we,
    input  logic [NWR-1:0][AW-1:0]    waddr,
    input  logic [NWR-1:0][WIDTH-1:0] wdata,
    input  logic [NRD-1:0][AW-1:0]    raddr,
    output logic [NRD-1:0][WIDTH-1:0] rdata,
    input  logic                      sb_set,
    input  logic [AW-1:0]             sb_addr,
    output logic [NRD-1:0]            rbusy,
    output logic [15:0]               wr_count
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [NWR-1:0]   wr_ok;
    logic [DEPTH-1:0] busy;
    logic [16:0]      inc;
    logic [16:0]      cnt_sum;

    // A write is live only out of reset and, with a hard-zero r0, not to r0.
    always_comb begin
        wr_ok = '0;
        for (int unsigned i = 0; i < NWR; i++) begin
            wr_ok[i] = we[i] && !rst && !(ZERO_REG && waddr[i] == '0);
        end
    end

    // Later write port wins through non-blocking ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
        end else begin
            for (int unsigned i = 0; i < NWR; i++) begin
                if (wr_ok[i]) regs[waddr[i]] <= wdata[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            rdata[j] = regs[raddr[j]];
            rbusy[j] = busy[raddr[j]];
            if (BYPASS) begin
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (wr_ok[i] && waddr[i] == raddr[j]) begin
                        rdata[j] = wdata[i];
                        rbusy[j] = 1'b0;
                    end
                end
            end
            if (rst || (ZERO_REG && raddr[j] == '0)) begin
                rdata[j] = '0;
                rbusy[j] = 1'b0;
            end
        end
    end

    // Count distinct registers: a port shadowed by a later same-address port is skipped.
    always_comb begin
        inc = '0;
        for (int unsigned i = 0; i < NWR; i++) begin
            logic shadowed;
            shadowed = 1'b0;
            for (int unsigned k = i + 1; k < NWR; k++) begin
                if (wr_ok[k] && waddr[k] == waddr[i]) shadowed = 1'b1;
            end
            if (wr_ok[i] && !shadowed) inc = inc + 17'd1;
        end
        cnt_sum = {1'b0, wr_count} + inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             wr_count <= '0;
        else if (cnt_sum[16]) wr_count <= 16'hFFFF;
        else                 wr_count <= cnt_sum[15:0];
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set      (sb_set),
        .set_addr (sb_addr),
        .clr      (wr_ok),
        .clr_addr (waddr),
        .busy     (busy)
    );

endmodule
